// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with accumulator and valid/ready flow control.
// Define APPROX_LOA_EN to replace the low APPROX_BITS sum bits with a lower-part OR adder.
module cla_pipe_adder #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned GROUP       = 4,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_t;

  localparam int unsigned NG = (WIDTH + GROUP - 1) / GROUP;
`ifdef APPROX_LOA_EN
  localparam int unsigned AB = APPROX_BITS;
`else
  localparam int unsigned AB = APPROX_BITS * 0;
`endif
  localparam logic [WIDTH-1:0] LMASK = {WIDTH{1'b1}} >> (WIDTH - AB);

  // Index 0 is the issue register; index s holds the result of lookahead stage s.
  logic [WIDTH-1:0] a_q [0:STAGES];
  logic [WIDTH-1:0] b_q [0:STAGES];
  logic [WIDTH-1:0] p_q [0:STAGES];
  logic [WIDTH-1:0] g_q [0:STAGES];
  logic [WIDTH-1:0] s_q [0:STAGES];
  logic             c_q [0:STAGES];
  logic             o_q [0:STAGES];
  logic             v_q [0:STAGES];
  mode_t            m_q [0:STAGES];

  logic [WIDTH-1:0] s_d [1:STAGES];
  logic             c_d [1:STAGES];
  logic             o_d [1:STAGES];

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] ia, ib, ip, ig;
  logic             ic;
  mode_t            im;
  logic             advance, acc_busy, accept, done;

  logic [WIDTH-1:0] s_t;
  logic             c_t, cb_t, gg_t, gp_t;

  assign advance   = !(v_q[STAGES] && !out_ready);
  assign in_ready  = rst_n && advance && !acc_busy;
  assign accept    = in_valid && in_ready;
  assign done      = v_q[STAGES] && out_ready;
  assign out_valid = v_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = o_q[STAGES];

  always_comb begin
    acc_busy = 1'b0;
    for (int unsigned st = 0; st <= STAGES; st++) begin
      if (v_q[st] && (m_q[st] == MODE_ACC || m_q[st] == MODE_CLR)) acc_busy = 1'b1;
    end
  end

  // Operand selection and per-bit propagate/generate at issue.
  always_comb begin
    im = mode_t'(mode);
    ia = '0;
    ib = '0;
    ic = 1'b0;
    case (im)
      MODE_ADD: begin ia = a;   ib = b;  ic = cin;  end
      MODE_SUB: begin ia = a;   ib = ~b; ic = 1'b1; end
      MODE_ACC: begin ia = acc; ib = a;  ic = 1'b0; end
      default:  begin ia = '0;  ib = '0; ic = 1'b0; end
    endcase
    if (AB != 0) ic = 1'b0;
    ip = ia ^ ib;
    ig = ia & ib;
    // Approximated bits feed no carry except the top one, which generates into bit AB.
    for (int unsigned i = 0; i < AB; i++) begin
      ip[i] = 1'b0;
      if (i + 1 < AB) ig[i] = 1'b0;
    end
  end

  // Each stage resolves its share of groups from the carry registered by the previous stage.
  always_comb begin
    s_t  = '0;
    c_t  = 1'b0;
    cb_t = 1'b0;
    gg_t = 1'b0;
    gp_t = 1'b0;
    for (int unsigned st = 1; st <= STAGES; st++) begin
      s_t = s_q[st-1];
      c_t = c_q[st-1];
      for (int unsigned k = (st - 1) * NG / STAGES; k < st * NG / STAGES; k++) begin
        cb_t = c_t;
        gg_t = 1'b0;
        gp_t = 1'b1;
        for (int unsigned j = 0; j < GROUP; j++) begin
          if (k * GROUP + j < WIDTH) begin
            s_t[k*GROUP+j] = p_q[st-1][k*GROUP+j] ^ cb_t;
            cb_t = g_q[st-1][k*GROUP+j] | (p_q[st-1][k*GROUP+j] & cb_t);
            gg_t = g_q[st-1][k*GROUP+j] | (p_q[st-1][k*GROUP+j] & gg_t);
            gp_t = gp_t & p_q[st-1][k*GROUP+j];
          end
        end
        c_t = gg_t | (gp_t & c_t);
      end
      s_t = (s_t & ~LMASK) | ((a_q[st-1] | b_q[st-1]) & LMASK);
      s_d[st] = s_t;
      c_d[st] = c_t;
      o_d[st] = (a_q[st-1][WIDTH-1] == b_q[st-1][WIDTH-1]) &&
                (s_t[WIDTH-1] != a_q[st-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned st = 0; st <= STAGES; st++) begin
        a_q[st] <= '0;
        b_q[st] <= '0;
        p_q[st] <= '0;
        g_q[st] <= '0;
        s_q[st] <= '0;
        c_q[st] <= 1'b0;
        o_q[st] <= 1'b0;
        v_q[st] <= 1'b0;
        m_q[st] <= MODE_ADD;
      end
      acc <= '0;
    end else begin
      if (advance) begin
        v_q[0] <= accept;
        a_q[0] <= ia;
        b_q[0] <= ib;
        p_q[0] <= ip;
        g_q[0] <= ig;
        s_q[0] <= '0;
        c_q[0] <= ic;
        o_q[0] <= 1'b0;
        m_q[0] <= im;
        for (int unsigned st = 1; st <= STAGES; st++) begin
          v_q[st] <= v_q[st-1];
          a_q[st] <= a_q[st-1];
          b_q[st] <= b_q[st-1];
          p_q[st] <= p_q[st-1];
          g_q[st] <= g_q[st-1];
          m_q[st] <= m_q[st-1];
          s_q[st] <= s_d[st];
          c_q[st] <= c_d[st];
          o_q[st] <= o_d[st];
        end
      end
      if (done) begin
        if (m_q[STAGES] == MODE_ACC) acc <= s_q[STAGES];
        else if (m_q[STAGES] == MODE_CLR) acc <= '0;
      end
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with an internal accumulator and a valid/ready handshake on both sides.
- Generalises the fixed 11-bit CLA used in the 6x6 approximate-multiplier datapath. Adds configurable width, lookahead group size and pipeline depth, plus subtract, accumulate, flow control and an optional lower-part-OR approximation.
- Sits between the partial-product reduction tree and the product/accumulate register.

Parameters:
- WIDTH, 11: operand and sum width in bits; legal range 4..64.
- GROUP, 4: carry-lookahead group size in bits. The last group may be partial.
- STAGES, 2: pipeline register stages, 1..4. Group-carry computation is split evenly across stages.
- APPROX_BITS, 4: number of low bits approximated when APPROX_LOA_EN is defined; 0..WIDTH-1. Ignored otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block accepts an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored in ACC/CLR modes)
- cin  in  1  carry-in (ADD mode only)
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; in SUB, 1 = no borrow
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset:
  - While rst_n=0 at a clk edge, all stage valids clear and the accumulator clears to 0.
  - Outputs are 0: out_valid, sum, cout, ovf.
  - in_ready=0 during reset, and 1 on the first cycle after reset.
- Reset mid-operation: all in-flight ops are discarded and no result is emitted.
- Acceptance: an op is accepted on a clk edge when in_valid & in_ready.
- Stall rule:
  - Pipeline advances when !(out_valid & !out_ready).
  - When stalled, every stage holds and the output registers are stable.
  - in_ready = advance & !acc_busy.
- Latency:
  - With no stall, an op accepted at edge N appears with out_valid=1 after edge N+STAGES.
  - Throughput is 1 op/cycle.
- Arithmetic (modulo 2^WIDTH):
  - ADD: a + b + cin.
  - SUB: a + ~b + 1 (cin ignored).
  - ACC: acc + a + 0.
  - CLR: sum=0, cout=0, ovf=0.
- ovf = (opA[MSB] == opB'[MSB]) & (sum[MSB] != opA[MSB]), where opB' is the effective second operand after inversion.
- Accumulator:
  - Updated to sum when an ACC op completes its output handshake.
  - Cleared to 0 when a CLR op completes its output handshake.
  - acc_busy=1 while any ACC or CLR op is in the pipeline or held at the output. This interlock forbids back-to-back accumulator hazards.
  - acc is read at issue. Because of the interlock, the next op is always issued after the previous ACC/CLR has retired.
- Carry chain:
  - Group propagate/generate per GROUP bits; group carries are resolved by lookahead across groups.
  - Stage boundaries register the partial sums and group carries only. No ripple across a stage boundary.
- Simultaneous events:
  - Output consumed and new input accepted in the same edge is legal, with no bubble.
  - in_valid held with in_ready=0 leaves the op unaccepted; the source must hold it.
- Output data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro APPROX_LOA_EN.
- Defined:
  - Bits [APPROX_BITS-1:0] of sum = opA | opB' (lower-part OR adder).
  - Carry into bit APPROX_BITS = opA[APPROX_BITS-1] & opB'[APPROX_BITS-1]. cin and SUB's +1 are not applied to the low part.
  - Upper bits use the exact CLA.
  - Latency is unchanged.
- Undefined: fully exact adder, and APPROX_BITS has no effect.

Test Plan (WIDTH=11, GROUP=4, STAGES=2):
- ADD a=0x3FF, b=0x3FF, cin=0 -> sum=0x7FE, cout=0, ovf=1, out_valid exactly 2 cycles after accept.
- ADD a=0x7FF, b=0x001, cin=0 -> sum=0x000, cout=1, ovf=0. SUB a=5, b=7 -> sum=0x7FE, cout=0, ovf=0.
- Back-pressure: stream 4 ADDs (a=1,2,3,4; b=0x10). Hold out_ready=0 for 3 cycles after the first result -> sum holds 0x011 and in_ready=0 while stalled. Results then appear in order 0x011, 0x012, 0x013, 0x014 with none lost or duplicated.
- Accumulate: CLR, then ACC a=0x100 three times -> results 0x000, 0x100, 0x200, 0x300. in_ready=0 while each ACC/CLR is in flight.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 2 ops in flight -> no out_valid afterwards, acc=0, and the next ACC a=0x005 gives sum=0x005.
- APPROX_LOA_EN, APPROX_BITS=4: ADD a=0x00F, b=0x001 -> sum=0x00F (exact build gives 0x010). a=0x008, b=0x008 -> sum=0x018.
